// File: rtl/snake_pkg.sv
// snake_pkg: board geometry, colour palette and 640x480@60 timing shared by the snake display
package snake_pkg;
  localparam int XSIZE = 48;
  localparam int YSIZE = 64;
  localparam int MAX_SIZE = 20;
  localparam int CW = 6;
  localparam int SW = 12;
  localparam int CELL = 10;
  localparam int PIX_DIV = 2;
  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_VIS = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_LAST = 10'd524;
  typedef logic [23:0] rgb_t;
  localparam rgb_t C_ITEM = 24'hFF0000;
  localparam rgb_t C_HEAD = 24'h00FF00;
  localparam rgb_t C_BODY = 24'h008000;
  localparam rgb_t C_WALL = 24'h808080;
  localparam rgb_t C_BG = 24'h000000;
  typedef struct packed {
    logic item;
    logic head;
    logic body;
    logic wall;
    logic vis;
    logic hs;
    logic vs;
  } pix_t;
  localparam pix_t PIX_IDLE = '{item: 1'b0, head: 1'b0, body: 1'b0, wall: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1};
  function automatic rgb_t pick_colour(input pix_t p);
    return !p.vis ? C_BG : p.item ? C_ITEM : p.head ? C_HEAD : p.body ? C_BODY : p.wall ? C_WALL : C_BG;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider, raster counters, divider-free cell indices and raw sync/blank
module vga_timing_gen
  import snake_pkg::*;
#(
  parameter int CELL = snake_pkg::CELL,
  parameter int PIX_DIV = snake_pkg::PIX_DIV
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       pe,
  output logic       pix_clk,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic [6:0] col,
  output logic [5:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       vis
);
  localparam logic [7:0] DIV_LAST = 8'(PIX_DIV - 1);
  localparam logic [7:0] DIV_HALF = 8'((PIX_DIV + 1) / 2);
  localparam logic [3:0] SUB_LAST = 4'(CELL - 1);
  logic [7:0] div;
  logic [3:0] hsub, vsub;
  logic h_wrap, v_wrap, hsub_wrap, vsub_wrap;
  assign pe = div == 8'd0;
  assign pix_clk = div < DIV_HALF;
  assign h_wrap = h == H_LAST;
  assign v_wrap = v == V_LAST;
  assign hsub_wrap = hsub == SUB_LAST;
  assign vsub_wrap = vsub == SUB_LAST;
  assign hsync = !(h >= H_SYNC_S && h < H_SYNC_E);
  assign vsync = !(v >= V_SYNC_S && v < V_SYNC_E);
  assign vis = h < H_VIS && v < V_VIS;
  // divider runs every clock; raster and cell counters step only on pe, lines advance on h wrap
  always_ff @(posedge i_Clk)
    if (!i_Rst) begin
      div <= '0;
      h <= '0;
      v <= '0;
      hsub <= '0;
      vsub <= '0;
      col <= '0;
      row <= '0;
    end else begin
      div <= div == DIV_LAST ? 8'd0 : div + 8'd1;
      if (pe) begin
        h <= h_wrap ? 10'd0 : h + 10'd1;
        hsub <= h_wrap || hsub_wrap ? 4'd0 : hsub + 4'd1;
        col <= h_wrap ? 7'd0 : col + {6'd0, hsub_wrap};
        if (h_wrap) begin
          v <= v_wrap ? 10'd0 : v + 10'd1;
          vsub <= v_wrap || vsub_wrap ? 4'd0 : vsub + 4'd1;
          row <= v_wrap ? 6'd0 : row + {5'd0, vsub_wrap};
        end
      end
    end
endmodule

// File: rtl/snake_vga_renderer.sv
// snake_vga_renderer: per-frame board snapshot rasterised to 640x480 VGA with a 2-pixel pipeline
module snake_vga_renderer
  import snake_pkg::*;
#(
  parameter int XSIZE = snake_pkg::XSIZE,
  parameter int YSIZE = snake_pkg::YSIZE,
  parameter int MAX_SIZE = snake_pkg::MAX_SIZE,
  parameter int CELL = snake_pkg::CELL,
  parameter int PIX_DIV = snake_pkg::PIX_DIV
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [MAX_SIZE*CW-1:0] i_Body_x,
  input  logic [MAX_SIZE*CW-1:0] i_Body_y,
  input  logic [CW-1:0]          i_Item_x,
  input  logic [CW-1:0]          i_Item_y,
  input  logic [SW-1:0]          i_Size,
  output logic                   o_Hsync,
  output logic                   o_Vsync,
  output logic [7:0]             o_Red,
  output logic [7:0]             o_Green,
  output logic [7:0]             o_Blue,
  output logic                   o_Blank_N,
  output logic                   o_Sync_N,
  output logic                   o_Pix_Clk,
  output logic                   o_Frame_Start
);
  localparam logic [5:0] ROW_LAST = 6'(XSIZE - 1);
  localparam logic [6:0] COL_LAST = 7'(YSIZE - 1);
  localparam logic [SW-1:0] SIZE_MAX = SW'(MAX_SIZE);
  logic pe, pix_clk, hs, vs, vis, snap_en;
  logic [9:0] h, v;
  logic [6:0] col;
  logic [5:0] row;
  logic [MAX_SIZE*CW-1:0] snap_bx, snap_by;
  logic [CW-1:0] snap_ix, snap_iy;
  logic [SW-1:0] snap_size;
  logic [MAX_SIZE-1:0] hit;
  pix_t cur, s1;
  rgb_t rgb_q;
  vga_timing_gen #(.CELL(CELL), .PIX_DIV(PIX_DIV)) u_timing (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .pe     (pe),
    .pix_clk(pix_clk),
    .h      (h),
    .v      (v),
    .col    (col),
    .row    (row),
    .hsync  (hs),
    .vsync  (vs),
    .vis    (vis)
  );
  assign snap_en = pe && h == 10'd0 && v == V_VIS;
  // snapshot at the top of vblank so a frame never mixes two game states; the item resets off-board
  always_ff @(posedge i_Clk)
    if (!i_Rst) begin
      snap_bx <= '0;
      snap_by <= '0;
      snap_ix <= '1;
      snap_iy <= '1;
      snap_size <= '0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Frame_Start <= snap_en;
      if (snap_en) begin
        snap_bx <= i_Body_x;
        snap_by <= i_Body_y;
        snap_ix <= i_Item_x;
        snap_iy <= i_Item_y;
        snap_size <= i_Size > SIZE_MAX ? SIZE_MAX : i_Size;
      end
    end
  for (genvar k = 0; k < MAX_SIZE; k++) begin : g_hit
    assign hit[k] = SW'(k) < snap_size && snap_bx[k*CW+:CW] == row && {1'b0, snap_by[k*CW+:CW]} == col;
  end
  // stage-0 classification of the current cell; syncs and blank ride along unchanged
  always_comb begin
    cur.item = snap_ix == row && {1'b0, snap_iy} == col;
    cur.head = hit[0];
    cur.body = |hit[MAX_SIZE-1:1];
    cur.wall = row == 6'd0 || row == ROW_LAST || col == 7'd0 || col == COL_LAST;
    cur.vis = vis;
    cur.hs = hs;
    cur.vs = vs;
  end
  // two pe-stages: register the match, then the colour and the aligned syncs/blank
  always_ff @(posedge i_Clk)
    if (!i_Rst) begin
      s1 <= PIX_IDLE;
      rgb_q <= C_BG;
      o_Hsync <= 1'b1;
      o_Vsync <= 1'b1;
      o_Blank_N <= 1'b0;
    end else if (pe) begin
      s1 <= cur;
      rgb_q <= pick_colour(s1);
      o_Hsync <= s1.hs;
      o_Vsync <= s1.vs;
      o_Blank_N <= s1.vis;
    end
  assign {o_Red, o_Green, o_Blue} = rgb_q;
  assign o_Sync_N = 1'b0;
  assign o_Pix_Clk = pix_clk;
endmodule
